// File: rtl/sc_pssched_pkg.sv
// Shared state encoding and default widths for the push-button strobe sequencer.
package sc_pssched_pkg;

  localparam int BURST_WIDTH_DEF = 4;
  localparam int GAP_WIDTH_DEF   = 4;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] LOAD = 3'd1;
  localparam logic [2:0] RAND = 3'd2;
  localparam logic [2:0] GAP  = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE = IDLE,
    S_LOAD = LOAD,
    S_RAND = RAND,
    S_GAP  = GAP,
    S_DONE = DONE
  } pss_state_e;

endpackage

// File: rtl/sc_pssched_if.sv
// Button/config inputs and RegGENERAL strobe/status outputs of the sequencer.
interface sc_pssched_if #(
  parameter int BURST_WIDTH = 4,
  parameter int GAP_WIDTH   = 4
);
  logic                   SC_PSSCHED_load_InLow;
  logic                   SC_PSSCHED_rand_InLow;
  logic [BURST_WIDTH-1:0] SC_PSSCHED_burst_InBUS;
  logic [GAP_WIDTH-1:0]   SC_PSSCHED_gap_InBUS;
  logic                   SC_PSSCHED_load_OutLow;
  logic                   SC_PSSCHED_rand_OutLow;
  logic                   SC_PSSCHED_busy_Out;
  logic                   SC_PSSCHED_done_Out;
  logic [BURST_WIDTH:0]   SC_PSSCHED_count_OutBUS;

  modport slave (
    input  SC_PSSCHED_load_InLow, SC_PSSCHED_rand_InLow,
           SC_PSSCHED_burst_InBUS, SC_PSSCHED_gap_InBUS,
    output SC_PSSCHED_load_OutLow, SC_PSSCHED_rand_OutLow,
           SC_PSSCHED_busy_Out, SC_PSSCHED_done_Out, SC_PSSCHED_count_OutBUS
  );

  modport master (
    output SC_PSSCHED_load_InLow, SC_PSSCHED_rand_InLow,
           SC_PSSCHED_burst_InBUS, SC_PSSCHED_gap_InBUS,
    input  SC_PSSCHED_load_OutLow, SC_PSSCHED_rand_OutLow,
           SC_PSSCHED_busy_Out, SC_PSSCHED_done_Out, SC_PSSCHED_count_OutBUS
  );
endinterface

// File: rtl/sc_pssched_edge.sv
// Falling-edge detector on an active-low button, latching into a sticky pending flag.
module sc_pssched_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn_n,
  input  logic i_clr,
  output logic o_pend
);

  logic r_hist;
  logic r_arm;
  logic r_pend;
  logic w_press;

  // r_arm blocks the first edge after reset so a button held through reset
  // only loads the history instead of counting as a fresh press.
  assign w_press = r_arm & r_hist & ~i_btn_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hist <= 1'b1;
      r_arm  <= 1'b0;
      r_pend <= 1'b0;
    end else begin
      r_hist <= i_btn_n;
      r_arm  <= 1'b1;
      if (w_press)    r_pend <= 1'b1;
      else if (i_clr) r_pend <= 1'b0;
    end
  end

  assign o_pend = r_pend;

endmodule

// File: rtl/sc_pssched_controller.sv
// Button-to-strobe sequencer: arbitrates load/rand presses, expands rand into timed bursts.
module sc_pssched_controller
  import sc_pssched_pkg::*;
#(
  parameter int BURST_WIDTH = BURST_WIDTH_DEF,
  parameter int GAP_WIDTH   = GAP_WIDTH_DEF
) (
  input  logic       SC_PSSCHED_CLOCK_50,
  input  logic       SC_PSSCHED_RESET_InLow,
  sc_pssched_if.slave bus
);

  localparam logic [BURST_WIDTH:0] CNT_FULL = {1'b1, {BURST_WIDTH{1'b0}}};

  pss_state_e             r_state, w_nstate;
  logic [BURST_WIDTH:0]   r_cnt, w_cnt_nxt;
  logic [GAP_WIDTH-1:0]   r_gap, w_gap_nxt;
  logic [GAP_WIDTH-1:0]   r_gcnt, w_gcnt_nxt;
  logic                   w_load_pend, w_rand_pend;
  logic                   w_load_clr, w_rand_clr;
  logic                   r_load_n, r_rand_n, r_busy, r_done;

  sc_pssched_edge u_load_edge (
    .clk     (SC_PSSCHED_CLOCK_50),
    .rst_n   (SC_PSSCHED_RESET_InLow),
    .i_btn_n (bus.SC_PSSCHED_load_InLow),
    .i_clr   (w_load_clr),
    .o_pend  (w_load_pend)
  );

  sc_pssched_edge u_rand_edge (
    .clk     (SC_PSSCHED_CLOCK_50),
    .rst_n   (SC_PSSCHED_RESET_InLow),
    .i_btn_n (bus.SC_PSSCHED_rand_InLow),
    .i_clr   (w_rand_clr),
    .o_pend  (w_rand_pend)
  );

  always_comb begin
    w_nstate   = r_state;
    w_cnt_nxt  = r_cnt;
    w_gap_nxt  = r_gap;
    w_gcnt_nxt = r_gcnt;
    w_load_clr = 1'b0;
    w_rand_clr = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_load_pend) begin
          w_nstate   = S_LOAD;
          w_load_clr = 1'b1;
        end else if (w_rand_pend) begin
          w_nstate   = S_RAND;
          w_rand_clr = 1'b1;
          w_cnt_nxt  = (bus.SC_PSSCHED_burst_InBUS == '0) ? CNT_FULL
                                                          : {1'b0, bus.SC_PSSCHED_burst_InBUS};
          w_gap_nxt  = bus.SC_PSSCHED_gap_InBUS;
        end
      end
      S_LOAD: w_nstate = S_DONE;
      S_RAND: begin
        w_cnt_nxt = r_cnt - 1'b1;
        if (r_cnt == {{BURST_WIDTH{1'b0}}, 1'b1}) w_nstate = S_DONE;
        else if (r_gap == '0)                       w_nstate = S_RAND;
        else begin
          w_nstate   = S_GAP;
          w_gcnt_nxt = r_gap;
        end
      end
      S_GAP: begin
        // Entered with gcnt=gap, leaves at gcnt=1: gap idle cycles between strobes.
        if (r_gcnt == {{(GAP_WIDTH-1){1'b0}}, 1'b1}) w_nstate = S_RAND;
        else                                         w_gcnt_nxt = r_gcnt - 1'b1;
      end
      S_DONE:  w_nstate = S_IDLE;
      default: w_nstate = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they change only on clock edges.
  always_ff @(posedge SC_PSSCHED_CLOCK_50 or negedge SC_PSSCHED_RESET_InLow) begin
    if (!SC_PSSCHED_RESET_InLow) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_gap    <= '0;
      r_gcnt   <= '0;
      r_load_n <= 1'b1;
      r_rand_n <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_nstate;
      r_cnt    <= w_cnt_nxt;
      r_gap    <= w_gap_nxt;
      r_gcnt   <= w_gcnt_nxt;
      r_load_n <= (w_nstate != S_LOAD);
      r_rand_n <= (w_nstate != S_RAND);
      r_busy   <= (w_nstate != S_IDLE);
      r_done   <= (w_nstate == S_DONE);
    end
  end

  assign bus.SC_PSSCHED_load_OutLow  = r_load_n;
  assign bus.SC_PSSCHED_rand_OutLow  = r_rand_n;
  assign bus.SC_PSSCHED_busy_Out     = r_busy;
  assign bus.SC_PSSCHED_done_Out     = r_done;
  assign bus.SC_PSSCHED_count_OutBUS = r_cnt;

endmodule

// File: tb/tb_sc_pssched_controller.sv
// Directed bench for sc_pssched_controller: reset hold, load, bursts, arbitration, mid-burst reset.
module tb_sc_pssched_controller;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_tot = 0;
  int   n_bad = 0;

  sc_pssched_if #(.BURST_WIDTH(4), .GAP_WIDTH(4)) bus ();

  sc_pssched_controller #(.BURST_WIDTH(4), .GAP_WIDTH(4)) dut (
    .SC_PSSCHED_CLOCK_50    (clk),
    .SC_PSSCHED_RESET_InLow (rst_n),
    .bus                    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_tot++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold selected buttons low across one edge (edge k), release; returns in cycle k.
  task automatic press(input bit do_load, input bit do_rand);
    if (do_load) bus.SC_PSSCHED_load_InLow = 1'b0;
    if (do_rand) bus.SC_PSSCHED_rand_InLow = 1'b0;
    step();
    bus.SC_PSSCHED_load_InLow = 1'b1;
    bus.SC_PSSCHED_rand_InLow = 1'b1;
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, "_load"},  int'(bus.SC_PSSCHED_load_OutLow), 1);
    chk({tag, "_rand"},  int'(bus.SC_PSSCHED_rand_OutLow), 1);
    chk({tag, "_busy"},  int'(bus.SC_PSSCHED_busy_Out), 0);
    chk({tag, "_done"},  int'(bus.SC_PSSCHED_done_Out), 0);
    chk({tag, "_count"}, int'(bus.SC_PSSCHED_count_OutBUS), 0);
  endtask

  // Watchdog: abort if the sequence never reaches its end.
  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int strobes;
    int busy_seen;

    bus.SC_PSSCHED_load_InLow  = 1'b0;
    bus.SC_PSSCHED_rand_InLow  = 1'b0;
    bus.SC_PSSCHED_burst_InBUS = 4'd3;
    bus.SC_PSSCHED_gap_InBUS   = 4'd2;

    // Reset with both buttons held; they must not trigger after release.
    repeat (3) step();
    chk_idle_outs("rst");
    rst_n = 1'b1;
    strobes = 0; busy_seen = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (!bus.SC_PSSCHED_load_OutLow || !bus.SC_PSSCHED_rand_OutLow) strobes++;
      if (bus.SC_PSSCHED_busy_Out) busy_seen++;
    end
    chk("hold_strobes", strobes, 0);
    chk("hold_busy", busy_seen, 0);
    bus.SC_PSSCHED_load_InLow = 1'b1;
    bus.SC_PSSCHED_rand_InLow = 1'b1;
    repeat (2) step();
    chk_idle_outs("hold_rel");

    // Single load.
    press(1'b1, 1'b0);
    chk("ld_k_load", int'(bus.SC_PSSCHED_load_OutLow), 1);
    chk("ld_k_busy", int'(bus.SC_PSSCHED_busy_Out), 0);
    for (int c = 1; c <= 3; c++) begin
      step();
      chk($sformatf("ld_load_c%0d", c), int'(bus.SC_PSSCHED_load_OutLow), (c == 1) ? 0 : 1);
      chk($sformatf("ld_rand_c%0d", c), int'(bus.SC_PSSCHED_rand_OutLow), 1);
      chk($sformatf("ld_done_c%0d", c), int'(bus.SC_PSSCHED_done_Out), (c == 2) ? 1 : 0);
      chk($sformatf("ld_busy_c%0d", c), int'(bus.SC_PSSCHED_busy_Out), (c <= 2) ? 1 : 0);
    end

    // Burst=3 gap=2; inputs changed mid-burst must be ignored.
    bus.SC_PSSCHED_burst_InBUS = 4'd3;
    bus.SC_PSSCHED_gap_InBUS   = 4'd2;
    press(1'b0, 1'b1);
    for (int c = 1; c <= 9; c++) begin
      step();
      chk($sformatf("b3_rand_c%0d", c), int'(bus.SC_PSSCHED_rand_OutLow),
          (c == 1 || c == 4 || c == 7) ? 0 : 1);
      chk($sformatf("b3_cnt_c%0d", c), int'(bus.SC_PSSCHED_count_OutBUS),
          (c < 2) ? 3 : (c < 5) ? 2 : (c < 8) ? 1 : 0);
      chk($sformatf("b3_done_c%0d", c), int'(bus.SC_PSSCHED_done_Out), (c == 8) ? 1 : 0);
      chk($sformatf("b3_load_c%0d", c), int'(bus.SC_PSSCHED_load_OutLow), 1);
      if (c == 2) begin
        bus.SC_PSSCHED_burst_InBUS = 4'd7;
        bus.SC_PSSCHED_gap_InBUS   = 4'd0;
      end
    end

    // Burst=0 means 16 back-to-back strobes.
    bus.SC_PSSCHED_burst_InBUS = 4'd0;
    bus.SC_PSSCHED_gap_InBUS   = 4'd0;
    press(1'b0, 1'b1);
    for (int c = 1; c <= 18; c++) begin
      step();
      chk($sformatf("b16_rand_c%0d", c), int'(bus.SC_PSSCHED_rand_OutLow), (c <= 16) ? 0 : 1);
      chk($sformatf("b16_done_c%0d", c), int'(bus.SC_PSSCHED_done_Out), (c == 17) ? 1 : 0);
      if (c <= 17)
        chk($sformatf("b16_cnt_c%0d", c), int'(bus.SC_PSSCHED_count_OutBUS), 17 - c);
    end

    // Burst=1: one strobe then DONE directly.
    bus.SC_PSSCHED_burst_InBUS = 4'd1;
    bus.SC_PSSCHED_gap_InBUS   = 4'd5;
    press(1'b0, 1'b1);
    for (int c = 1; c <= 3; c++) begin
      step();
      chk($sformatf("b1_rand_c%0d", c), int'(bus.SC_PSSCHED_rand_OutLow), (c == 1) ? 0 : 1);
      chk($sformatf("b1_done_c%0d", c), int'(bus.SC_PSSCHED_done_Out), (c == 2) ? 1 : 0);
      chk($sformatf("b1_busy_c%0d", c), int'(bus.SC_PSSCHED_busy_Out), (c <= 2) ? 1 : 0);
    end

    // Simultaneous press: load first, rand served on next IDLE visit.
    bus.SC_PSSCHED_burst_InBUS = 4'd1;
    press(1'b1, 1'b1);
    for (int c = 1; c <= 6; c++) begin
      step();
      chk($sformatf("arb_load_c%0d", c), int'(bus.SC_PSSCHED_load_OutLow), (c == 1) ? 0 : 1);
      chk($sformatf("arb_rand_c%0d", c), int'(bus.SC_PSSCHED_rand_OutLow), (c == 4) ? 0 : 1);
      chk($sformatf("arb_done_c%0d", c), int'(bus.SC_PSSCHED_done_Out),
          (c == 2 || c == 5) ? 1 : 0);
      chk($sformatf("arb_busy_c%0d", c), int'(bus.SC_PSSCHED_busy_Out),
          (c == 3 || c == 6) ? 0 : 1);
    end

    // Load pressed mid-burst is served after the burst's DONE.
    bus.SC_PSSCHED_burst_InBUS = 4'd2;
    bus.SC_PSSCHED_gap_InBUS   = 4'd3;
    press(1'b0, 1'b1);
    for (int c = 1; c <= 10; c++) begin
      step();
      chk($sformatf("lb_rand_c%0d", c), int'(bus.SC_PSSCHED_rand_OutLow),
          (c == 1 || c == 5) ? 0 : 1);
      chk($sformatf("lb_load_c%0d", c), int'(bus.SC_PSSCHED_load_OutLow), (c == 8) ? 0 : 1);
      chk($sformatf("lb_done_c%0d", c), int'(bus.SC_PSSCHED_done_Out),
          (c == 6 || c == 9) ? 1 : 0);
      chk($sformatf("lb_busy_c%0d", c), int'(bus.SC_PSSCHED_busy_Out),
          (c == 7 || c == 10) ? 0 : 1);
      bus.SC_PSSCHED_load_InLow = (c == 2) ? 1'b0 : 1'b1;
    end

    // Reset asserted after the 3rd strobe of an 8-strobe burst.
    bus.SC_PSSCHED_burst_InBUS = 4'd8;
    bus.SC_PSSCHED_gap_InBUS   = 4'd1;
    press(1'b0, 1'b1);
    strobes = 0;
    for (int c = 1; c <= 6; c++) begin
      step();
      if (!bus.SC_PSSCHED_rand_OutLow) strobes++;
    end
    chk("mr_strobes", strobes, 3);
    chk("mr_busy_pre", int'(bus.SC_PSSCHED_busy_Out), 1);
    chk("mr_cnt_pre", int'(bus.SC_PSSCHED_count_OutBUS), 5);
    #1 rst_n = 1'b0;
    #1 chk_idle_outs("mr_async");
    strobes = 0;
    for (int c = 0; c < 3; c++) begin
      step();
      if (!bus.SC_PSSCHED_load_OutLow || !bus.SC_PSSCHED_rand_OutLow) strobes++;
    end
    rst_n = 1'b1;
    busy_seen = 0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (!bus.SC_PSSCHED_load_OutLow || !bus.SC_PSSCHED_rand_OutLow) strobes++;
      if (bus.SC_PSSCHED_busy_Out) busy_seen++;
    end
    chk("mr_post_strobes", strobes, 0);
    chk("mr_post_busy", busy_seen, 0);

    // A fresh press after reset works again.
    bus.SC_PSSCHED_burst_InBUS = 4'd1;
    press(1'b0, 1'b1);
    step();
    chk("post_rand", int'(bus.SC_PSSCHED_rand_OutLow), 0);
    chk("post_cnt", int'(bus.SC_PSSCHED_count_OutBUS), 1);
    step();
    chk("post_done", int'(bus.SC_PSSCHED_done_Out), 1);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
